deck_shuffler: RTL

- Parametrised successor to the card shuffler. Performs an in-place Fisher-Yates shuffle of a DECK_SIZE-entry deck held in an external single-port synchronous RAM.
- Swap index is drawn from an internal 16-bit LFSR, seedable at run time.
- Sits between the game FSM (start/done handshake) and the deck RAM (addr/wdata/wren/rdata).

---
 rtl/deck_pkg.sv | 28 ++
 rtl/deck_lfsr.sv | 28 ++
 rtl/deck_shuffler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/deck_pkg.sv
// Shared types and constants for the deck shuffler: FSM states, LFSR width/taps, seed-zero substitute.
// Pure declarations; no latency or flow control of its own.
package deck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ADDR_I,
    ADDR_J,
    CAP_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

  localparam int LFSR_W = 16;

  // Feedback taps l[15], l[13], l[12], l[10].
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // An all-zero LFSR would lock up, so a zero seed becomes this value.
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 16'h0001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// 16-bit Fibonacci LFSR with run-time seed load; zero seeds map to a non-zero value.
// Load or advance take effect on the next clock edge; no backpressure, load wins over advance.
module deck_lfsr
  import deck_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] RESET_VAL = (SEED == '0) ? SEED_ZERO_SUB : SEED;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= (seed == '0) ? SEED_ZERO_SUB : seed;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/deck_shuffler.sv
// In-place Fisher-Yates shuffle of a RAM-held deck; DECK_SHUFFLER_INIT_EN adds an identity fill first.
// 5 cycles per swap (+DECK_SIZE cycles of fill); start/seed_load ignored unless idle, no backpressure.
module deck_shuffler
  import deck_pkg::*;
#(
  parameter int                DECK_SIZE = 52,
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 6,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DECK_SIZE - 1);
  localparam bit                SINGLE   = (DECK_SIZE == 1);
  localparam int                PROD_W   = 2 * ADDR_W + 1;

  if (DECK_SIZE < 1 || DECK_SIZE > (1 << ADDR_W)) begin : g_bad_size
    $error("deck_shuffler: DECK_SIZE must be within 1..2**ADDR_W");
  end

`ifdef DECK_SHUFFLER_INIT_EN
  if ((1 << DATA_W) < DECK_SIZE) begin : g_bad_width
    $error("deck_shuffler: DATA_W too narrow to hold every card index");
  end
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx_i, idx_j, j_calc, rnd;
  logic [DATA_W-1:0] val_i, val_j;
  logic [LFSR_W-1:0] lfsr_val;
  logic [PROD_W-1:0] prod;
  logic              lfsr_load, lfsr_adv;
`ifdef DECK_SHUFFLER_INIT_EN
  logic [ADDR_W-1:0] init_k;
`endif

  deck_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (lfsr_load),
    .seed   (seed),
    .advance(lfsr_adv),
    .value  (lfsr_val)
  );

  assign lfsr_load = (state == IDLE) && seed_load;

  // Scaling r by (i+1) and keeping the top ADDR_W bits lands j in 0..i without a modulo.
  assign rnd    = ADDR_W'(lfsr_val);
  assign prod   = PROD_W'(rnd) * (PROD_W'(idx_i) + PROD_W'(1));
  assign j_calc = ADDR_W'(prod >> ADDR_W);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
`ifdef DECK_SHUFFLER_INIT_EN
          state_nxt = INIT;
`else
          state_nxt = SINGLE ? DONE : ADDR_I;
`endif
        end
      end
`ifdef DECK_SHUFFLER_INIT_EN
      INIT: begin
        mem_addr  = init_k;
        mem_wdata = DATA_W'(init_k);
        mem_wren  = 1'b1;
        if (init_k == LAST_IDX) begin
          state_nxt = SINGLE ? DONE : ADDR_I;
        end
      end
`endif
      ADDR_I: begin
        mem_addr  = idx_i;
        state_nxt = ADDR_J;
      end
      ADDR_J: begin
        mem_addr  = idx_j;
        state_nxt = CAP_J;
      end
      CAP_J: begin
        state_nxt = WR_I;
      end
      WR_I: begin
        mem_addr  = idx_i;
        mem_wdata = val_j;
        mem_wren  = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        mem_addr  = idx_j;
        mem_wdata = val_i;
        mem_wren  = 1'b1;
        lfsr_adv  = 1'b1;
        state_nxt = (idx_i == ADDR_W'(1)) ? DONE : ADDR_I;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Each capture state sees the RAM word addressed in the previous cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_i  <= '0;
      idx_j  <= '0;
      val_i  <= '0;
      val_j  <= '0;
`ifdef DECK_SHUFFLER_INIT_EN
      init_k <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx_i  <= LAST_IDX;
`ifdef DECK_SHUFFLER_INIT_EN
            init_k <= '0;
`endif
          end
        end
`ifdef DECK_SHUFFLER_INIT_EN
        INIT:    init_k <= init_k + ADDR_W'(1);
`endif
        ADDR_I:  idx_j <= j_calc;
        ADDR_J:  val_i <= mem_rdata;
        CAP_J:   val_j <= mem_rdata;
        WR_J:    idx_i <= idx_i - ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule
